ref_dac_ctrl: RTL and testbench
===============================

// Module: ref_dac_ctrl
// PURPOSE
//  Board-level top that programs an external reference DAC over a 3-wire serial link
//  (SDI_REF/CLK_REF/CS_REF1) and drives the reference mux select (MUX_REF1).
//  The DAC code and mux select come from on-board switches. sw[0] is the board reset.
//  A 16-bit frame is sent after reset and again whenever the switch code changes.
// PARAMETERS
//  CLK_DIV   2        clk cycles per CLK_REF half-period (>=1)
//  WORD_W    16       serial frame length, MSB first
//  CMD       4'b0011  command nibble in frame bits [15:12] (write and update)
//  CS_GAP    4        min clk cycles CS_REF1 stays high between frames
//  REFRESH   1000000  clk cycles between forced re-sends (REF_AUTO_REFRESH_EN only)
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  sw[0]     in   1  rst_n: synchronous, active-low reset (bit 0 of sw)
//  sw[7:1]   in   7  sw[1] = mux select; sw[7:2] = 6-bit DAC code; async, 2-FF synced
//  SDI_REF   out  1  serial data to DAC, MSB first
//  CS_REF1   out  1  DAC chip select, active low, framing one word
//  CLK_REF   out  1  serial clock, idles low (CPOL=0); DAC samples SDI on rising edge
//  MUX_REF1  out  1  reference mux select = synced sw[1]
// BEHAVIOUR
//  - Reset (sw[0]==0 at a clk edge): CS_REF1=1, CLK_REF=0, SDI_REF=0, MUX_REF1=0;
//    the FSM goes to IDLE with pend=1. Reset mid-frame aborts the frame at the next edge.
//  - Frame word = {CMD, code[5:0], 6'b000000}. Example: code 6'h3F gives 16'h3FC0.
//  - FSM states and transitions:
//    - IDLE -> LOAD when pend=1. LOAD latches the word and clears pend.
//    - LOAD -> SETUP. SETUP drives CS_REF1=0, SDI=bit15, and holds CLK_DIV cycles.
//    - SETUP -> SHIFT. In SHIFT each bit is CLK_REF low for CLK_DIV cycles, then high
//      for CLK_DIV cycles. SDI changes only on the CLK_REF falling edge.
//    - After the 16th high phase, CLK_REF=0 for CLK_DIV cycles, then CS_REF1=1.
//    - SHIFT -> GAP. GAP holds CS_REF1 high for CS_GAP cycles, then -> IDLE.
//  - Frame length = 16 rising CLK_REF edges exactly. CS_REF1 is low for
//    (2*WORD_W+2)*CLK_DIV clk cycles (68 cycles at defaults).
//  - Code change: a change in synced sw[7:2] versus the last latched code sets pend.
//    - A change during a frame does not disturb that frame.
//    - One follow-up frame carries the newest code; intermediate values are dropped.
//  - MUX_REF1 follows synced sw[1] with 3-cycle latency, independent of the FSM.
//    It never triggers a frame.
//  - sw[1] toggling every 5 clk cycles must not affect CLK_REF, CS_REF1 or SDI_REF.
// CONFIGURATION
//  REF_AUTO_REFRESH_EN defined:
//    - A counter sets pend every REFRESH cycles while not in reset.
//    - The counter restarts at every LOAD.
//  Not defined:
//    - Frames are sent only after reset and on code change.
//    - No refresh counter is present.
// STRUCTURE
//  - Package ref_dac_pkg holds the state enum (IDLE, LOAD, SETUP, SHIFT, GAP), the
//    CMD constant, and the WORD_W/CLK_DIV defaults.
//  - Sub-module ref_spi_tx: shift engine (divider, bit counter, CS/CLK/SDI regs) with a
//    start/busy handshake. start is accepted only when busy=0; busy rises next cycle.
//  - The top holds the switch synchronizers, change detection, pend logic and mux register.
// TESTING
//  - Reset behaviour: sw=8'hFF, sw[0] low for 40 cycles, then high.
//    - During reset: CS_REF1=1, CLK_REF=0, SDI_REF=0, MUX_REF1=0.
//    - After release: one frame 16'h3FC0, 16 CLK_REF pulses, CS low 68 cycles.
//  - Code change: set sw[7:2]=6'h15 in the GAP state.
//    - The next frame is 16'h3540. No frame occurs while the code is unchanged.
//  - Mid-frame change: change sw[7:2] 6'h3F -> 6'h01 -> 6'h02 during a frame.
//    - The current frame completes unchanged.
//    - Exactly one follow-up frame 16'h3080 is sent.
//  - Reset mid-frame: assert sw[0]=0 at bit 7.
//    - Next edge: CS_REF1=1, CLK_REF=0.
//    - On release a full frame is re-sent from bit 15.
//  - Mux select: toggle sw[1] every 5 cycles.
//    - MUX_REF1 tracks it with 3-cycle latency; no extra frames are generated.
//  - REF_AUTO_REFRESH_EN with REFRESH=200 and a constant code:
//    - Frames repeat every 200 cycles, measured from each LOAD.

Source files
------------

// File: rtl/ref_dac_pkg.sv
// Shared types and constants for the reference DAC controller.
// Frame layout is {CMD, code[5:0], 6'b0}, WORD_W bits, MSB first.
package ref_dac_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned CLK_DIV_DEF = 2;
    localparam logic [3:0]  CMD         = 4'b0011;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSetup,
        StShift,
        StGap
    } tx_state_e;

    function automatic logic [WORD_W-1:0] frame_word(input logic [5:0] code);
        return {CMD, code, 6'b000000};
    endfunction

endpackage

// File: rtl/ref_dac_ctrl_if.sv
// Board-side pins of the reference DAC controller: 3-wire serial link plus mux select.
interface ref_dac_ctrl_if;

    logic SDI_REF;
    logic CS_REF1;
    logic CLK_REF;
    logic MUX_REF1;

    modport master (output SDI_REF, output CS_REF1, output CLK_REF, output MUX_REF1);
    modport slave  (input  SDI_REF, input  CS_REF1, input  CLK_REF, input  MUX_REF1);

endinterface

// File: rtl/ref_spi_tx.sv
// Serial shift engine: one WORD_W frame per accepted start, CPOL=0, MSB first.
// start_i is taken only while busy_o is low; busy_o rises the following cycle.
module ref_spi_tx
    import ref_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              busy_o,
    output logic              sdi_o,
    output logic              cs_no,
    output logic              sclk_o
);

    localparam int unsigned CntMax = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned HalfW  = $clog2(2 * WORD_W + 1);

    localparam logic [CntW-1:0]  DivLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  GapLast  = CntW'(CS_GAP - 1);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * WORD_W);

    tx_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            half_q  <= '0;
            word_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            word_q  <= word_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
        end
    end

    // Half-periods 0..2*WORD_W: even = CLK_REF low, odd = high, the last even one is the tail.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        word_d  = word_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    word_d  = word_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StSetup;
                cnt_d   = '0;
                half_d  = '0;
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                shreg_d = word_q;
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (half_q == HalfLast) begin
                        cs_d    = 1'b1;
                        state_d = StGap;
                    end else begin
                        half_d = half_q + 1'b1;
                        if (!half_q[0]) begin
                            sclk_d = 1'b1;
                        end else begin
                            // SDI advances only on the falling edge of CLK_REF.
                            sclk_d  = 1'b0;
                            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o = (state_q != StIdle);
    assign sdi_o  = shreg_q[WORD_W-1];
    assign cs_no  = cs_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/ref_dac_ctrl.sv
// Board top: syncs switches, resends the DAC frame on reset/code change, drives mux select.
// Optional REF_AUTO_REFRESH_EN adds a periodic forced resend every REFRESH cycles.
module ref_dac_ctrl
    import ref_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned CS_GAP  = 4
`ifdef REF_AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH = 1000000
`endif
) (
    input  logic           clk,
    input  logic [7:0]     sw,
    ref_dac_ctrl_if.master dac
);

    logic              rst_n;
    logic [6:0]        sync1_q, sync2_q;
    logic              pend_q, pend_d;
    logic [5:0]        code_q, code_d;
    logic              mux_q, mux_d;
    logic              busy;
    logic              accept;
    logic              code_chg;
    logic              refresh_hit;
    logic [WORD_W-1:0] word;
    logic              sdi, cs_n, sclk;

    assign rst_n = sw[0];

    // Synchronizers keep sampling through reset so the first frame sees the real code.
    always_ff @(posedge clk) begin
        sync1_q <= sw[7:1];
        sync2_q <= sync1_q;
    end

    assign accept   = pend_q & ~busy;
    assign code_chg = (sync2_q[6:1] != code_q);
    assign word     = frame_word(sync2_q[6:1]);

`ifdef REF_AUTO_REFRESH_EN
    localparam int unsigned RefW = $clog2(REFRESH);

    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;

    // Fires one cycle early so the next LOAD lands exactly REFRESH cycles after the last.
    assign refresh_hit = (ref_cnt_q == RefW'(REFRESH - 2));

    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        if (accept || ref_cnt_q == RefW'(REFRESH - 1)) begin
            ref_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    always_comb begin
        pend_d = pend_q | code_chg | refresh_hit;
        code_d = code_q;
        mux_d  = sync2_q[0];
        if (accept) begin
            pend_d = 1'b0;
            code_d = sync2_q[6:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b1;
            code_q <= '0;
            mux_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            code_q <= code_d;
            mux_q  <= mux_d;
        end
    end

    ref_spi_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_tx (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (pend_q),
        .word_i  (word),
        .busy_o  (busy),
        .sdi_o   (sdi),
        .cs_no   (cs_n),
        .sclk_o  (sclk)
    );

    assign dac.SDI_REF  = sdi;
    assign dac.CS_REF1  = cs_n;
    assign dac.CLK_REF  = sclk;
    assign dac.MUX_REF1 = mux_q;

endmodule

// File: tb/tb_ref_dac_ctrl.sv
// Directed bench for ref_dac_ctrl: a pin-level monitor decodes frames and checks them
// against a queue of expected words filled as stimulus is applied.
module tb_ref_dac_ctrl;

    logic       clk = 1'b0;
    logic [7:0] sw;
    logic [5:0] code_v;
    logic       mux_v;
    logic       rst_v;

    int          vectors     = 0;
    int          miscompares = 0;
    int          frames_done = 0;
    int          aborted     = 0;
    int          edges       = 0;
    int          low_cnt     = 0;
    int unsigned cyc         = 0;
    bit          expect_abort = 1'b0;
    bit          stray        = 1'b0;
    bit          in_frame     = 1'b0;
    logic        prev_sclk    = 1'b0;
    logic [15:0] shift        = '0;

    logic [31:0] exp_q[$];
    int unsigned fall_cyc[$];

    always #5 clk = ~clk;

    ref_dac_ctrl_if dac ();

    ref_dac_ctrl #(
        .CLK_DIV (2),
        .CS_GAP  (4)
`ifdef REF_AUTO_REFRESH_EN
        ,
        .REFRESH (200)
`endif
    ) dut (
        .clk (clk),
        .sw  (sw),
        .dac (dac)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        sw = {code_v, mux_v, rst_v};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int i = 0;
        while (frames_done < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, frames_done, n);
    endtask

    task automatic wait_cs_low(input int budget, input string tag);
        int i = 0;
        while (dac.CS_REF1 !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, dac.CS_REF1, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pin monitor: sample on the falling clk edge, away from the DUT's active edge.
    initial forever begin
        logic [31:0] exp_w;
        @(negedge clk);
        if (!in_frame) begin
            if (dac.CS_REF1 === 1'b1 && dac.CLK_REF === 1'b1) stray = 1'b1;
            if (dac.CS_REF1 === 1'b0) begin
                in_frame  = 1'b1;
                edges     = 0;
                low_cnt   = 1;
                shift     = '0;
                prev_sclk = dac.CLK_REF;
                fall_cyc.push_back(cyc);
            end
        end else if (dac.CS_REF1 === 1'b0) begin
            low_cnt++;
            if (dac.CLK_REF === 1'b1 && prev_sclk === 1'b0) begin
                shift = {shift[14:0], dac.SDI_REF};
                edges++;
            end
            prev_sclk = dac.CLK_REF;
        end else begin
            in_frame = 1'b0;
            if (expect_abort) begin
                expect_abort = 1'b0;
                aborted++;
                check("abort_short", (edges < 16) ? 1 : 0, 1);
            end else begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("frame_word", {16'h0, shift}, exp_w);
                check("frame_edges", edges, 16);
                check("frame_cs_low", low_cnt, 68);
                frames_done++;
            end
        end
    end

    initial begin
        code_v = 6'h3F;
        mux_v  = 1'b1;
        rst_v  = 1'b0;
        apply();
        cycles(5);
        check("rst_cs", dac.CS_REF1, 1);
        check("rst_clk", dac.CLK_REF, 0);
        check("rst_sdi", dac.SDI_REF, 0);
        check("rst_mux", dac.MUX_REF1, 0);
        cycles(35);

`ifdef REF_AUTO_REFRESH_EN
        repeat (4) exp_q.push_back(32'h3FC0);
        rst_v = 1'b1;
        apply();
        wait_frames(4, 1200, "refresh_frames");
        for (int i = 1; i < 4; i++) begin
            if (fall_cyc.size() > i) check("refresh_period", fall_cyc[i] - fall_cyc[i-1], 200);
            else check("refresh_period_missing", fall_cyc.size(), 4);
        end
`else
        // Reset release: one frame with the switch code, then a code change during GAP.
        exp_q.push_back(32'h3FC0);
        exp_q.push_back(32'h3540);
        rst_v = 1'b1;
        apply();
        wait_frames(1, 400, "first_frame");
        check("mux_after_rst", dac.MUX_REF1, 1);
        code_v = 6'h15;
        apply();
        wait_frames(2, 400, "gap_change_frame");
        cycles(300);
        check("no_frame_idle", frames_done, 2);

        // Mid-frame changes: current frame intact, one follow-up with the newest code.
        code_v = 6'h3F;
        apply();
        exp_q.push_back(32'h3FC0);
        exp_q.push_back(32'h3080);
        wait_cs_low(50, "midframe_start");
        cycles(10);
        code_v = 6'h01;
        apply();
        cycles(10);
        code_v = 6'h02;
        apply();
        wait_frames(4, 600, "midframe_frames");
        cycles(200);
        check("single_followup", frames_done, 4);

        // Reset during bit 7 aborts the frame; release resends it from bit 15.
        code_v = 6'h2A;
        apply();
        wait_cs_low(50, "abort_start");
        begin
            int i = 0;
            while (edges < 8 && i < 100) begin
                @(negedge clk);
                i++;
            end
            check("reach_bit7", (edges >= 8) ? 1 : 0, 1);
        end
        expect_abort = 1'b1;
        rst_v = 1'b0;
        apply();
        cycles(1);
        check("abort_cs", dac.CS_REF1, 1);
        check("abort_clk", dac.CLK_REF, 0);
        cycles(4);
        exp_q.push_back(32'h3A80);
        rst_v = 1'b1;
        apply();
        wait_frames(5, 400, "resend_frame");
        check("aborted_count", aborted, 1);
        cycles(100);

        // Mux select toggling: exact 3-cycle latency and no frames triggered.
        for (int i = 0; i < 12; i++) begin
            mux_v = ~mux_v;
            apply();
            cycles(2);
            check("mux_hold", dac.MUX_REF1, {31'h0, ~mux_v});
            cycles(1);
            check("mux_follow", dac.MUX_REF1, {31'h0, mux_v});
            cycles(2);
        end
        cycles(100);
        check("mux_no_frames", frames_done, 5);
`endif

        check("no_stray_clk", stray, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
